// File: rtl/data_unpack_pkg.sv
// Shared constants and helpers for the bit-stream unpacker.
package data_unpack_pkg;

    localparam int DEF_IN_W        = 32;
    localparam int DEF_OUT_W       = 7;
    localparam bit DEF_MSB_FIRST   = 1'b0;
    localparam bit DEF_PAD_PARTIAL = 1'b1;

    // Width needed to count 0..acc_w valid bits.
    function automatic int lvl_w(input int acc_w);
        return $clog2(acc_w + 1);
    endfunction

endpackage

// File: rtl/unpack_shift_acc.sv
// Accumulator register: inserts a word at the current fill offset and
// shifts one packet out per pop. Bits outside the valid region stay zero,
// so insertion is a plain OR and a partial packet reads its missing bits as 0.
module unpack_shift_acc
    import data_unpack_pkg::*;
#(
    parameter int  IN_W      = DEF_IN_W,
    parameter int  OUT_W     = DEF_OUT_W,
    parameter bit  MSB_FIRST = DEF_MSB_FIRST,
    localparam int ACC_W     = IN_W + OUT_W - 1,
    localparam int LVL_W     = lvl_w(ACC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [IN_W-1:0]  push_data,
    input  logic [LVL_W-1:0] level,
    output logic [OUT_W-1:0] pkt
);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] ins_s;
    logic [ACC_W-1:0] shifted_s;

    // Word placed at the fill offset, and accumulator contents after one pop.
    always_comb begin
        ins_s     = {ACC_W{1'b0}};
        shifted_s = acc_r;
        if (MSB_FIRST) begin
            ins_s     = (ACC_W'(push_data) << (ACC_W - IN_W)) >> level;
            shifted_s = acc_r << OUT_W;
        end else begin
            ins_s     = ACC_W'(push_data) << level;
            shifted_s = acc_r >> OUT_W;
        end
    end

    // Packet presented at the output end of the accumulator.
    always_comb begin
        if (MSB_FIRST) begin
            pkt = acc_r[ACC_W-1 -: OUT_W];
        end else begin
            pkt = acc_r[OUT_W-1:0];
        end
    end

    // Accumulator state: clear on reset or discard, else push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clr) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (push) begin
            acc_r <= acc_r | ins_s;
        end else if (pop) begin
            acc_r <= shifted_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/data_unpack_stream.sv
// Bit-stream unpacker: IN_W-bit words in, OUT_W-bit packets out, residue
// carried between words, final partial packet padded or dropped.
module data_unpack_stream
    import data_unpack_pkg::*;
#(
    parameter int  IN_W        = DEF_IN_W,
    parameter int  OUT_W       = DEF_OUT_W,
    parameter bit  MSB_FIRST   = DEF_MSB_FIRST,
    parameter bit  PAD_PARTIAL = DEF_PAD_PARTIAL,
    localparam int ACC_W       = IN_W + OUT_W - 1,
    localparam int LVL_W       = lvl_w(ACC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [LVL_W-1:0] level,
    output logic             drop_pulse
);

    localparam logic [LVL_W-1:0] IN_W_L      = LVL_W'(IN_W);
    localparam logic [LVL_W-1:0] OUT_W_L     = LVL_W'(OUT_W);
    localparam logic [LVL_W:0]   TWO_OUT_W_L = (LVL_W + 1)'(2 * OUT_W);

    generate
        if (OUT_W > IN_W || OUT_W < 1) begin : g_bad_width
            $error("data_unpack_stream: OUT_W must be in 1..IN_W");
        end
    endgenerate

    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_n_s;
    logic             pending_last_r;
    logic             pending_last_n_s;
    logic             full_s;
    logic             partial_s;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             clr_s;

    // Handshake and status outputs, derived only from registered state.
    always_comb begin
        full_s     = (level_r >= OUT_W_L);
        partial_s  = pending_last_r && (level_r != {LVL_W{1'b0}}) && (level_r < OUT_W_L);
        in_ready   = !pending_last_r && (level_r < OUT_W_L);
        out_valid  = full_s || (PAD_PARTIAL && partial_s);
        drop_pulse = !PAD_PARTIAL && partial_s;
        if (PAD_PARTIAL) begin
            out_last = out_valid && pending_last_r && (level_r <= OUT_W_L);
        end else begin
            out_last = out_valid && pending_last_r && ({1'b0, level_r} < TWO_OUT_W_L);
        end
        in_fire_s  = in_valid && in_ready;
        out_fire_s = out_valid && out_ready;
        level      = level_r;
    end

    // Next fill level and end-of-stream flag; push and pop are exclusive.
    always_comb begin
        level_n_s        = level_r;
        pending_last_n_s = pending_last_r;
        clr_s            = 1'b0;
        if (in_fire_s) begin
            level_n_s        = level_r + IN_W_L;
            pending_last_n_s = in_last;
        end else if (out_fire_s) begin
            if (full_s) begin
                level_n_s = level_r - OUT_W_L;
            end else begin
                level_n_s = {LVL_W{1'b0}};
            end
            if (level_n_s == {LVL_W{1'b0}}) begin
                pending_last_n_s = 1'b0;
            end else begin
                pending_last_n_s = pending_last_r;
            end
        end else if (drop_pulse) begin
            level_n_s        = {LVL_W{1'b0}};
            pending_last_n_s = 1'b0;
            clr_s            = 1'b1;
        end else begin
            level_n_s        = level_r;
            pending_last_n_s = pending_last_r;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r        <= {LVL_W{1'b0}};
            pending_last_r <= 1'b0;
        end else begin
            level_r        <= level_n_s;
            pending_last_r <= pending_last_n_s;
        end
    end

    unpack_shift_acc #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .push      (in_fire_s),
        .pop       (out_fire_s),
        .push_data (in_data),
        .level     (level_r),
        .pkt       (out_data)
    );

endmodule

// File: tb/tb_data_unpack_stream.sv
// Bench for data_unpack_stream: three instances (LSB/pad, LSB/drop, MSB/pad),
// a table of single-word vectors plus stream, backpressure and reset sequences.
module tb_data_unpack_stream;

    logic        clk;
    logic        rst;
    logic [31:0] in_data    [3];
    logic        in_valid   [3];
    logic        in_last    [3];
    logic        in_ready   [3];
    logic [6:0]  out_data   [3];
    logic        out_valid  [3];
    logic        out_last   [3];
    logic        out_ready  [3];
    logic [5:0]  level      [3];
    logic        drop_pulse [3];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          k;
        logic [31:0] word;
        bit          last;
        int          n;
        logic [6:0]  first;
        logic [6:0]  fin;
        bit          fin_last;
        int          drops;
        int          lvl;
    } vec_t;

    data_unpack_stream #(.IN_W(32), .OUT_W(7), .MSB_FIRST(1'b0), .PAD_PARTIAL(1'b1)) dut_pad (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
        .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
        .out_last(out_last[0]), .out_ready(out_ready[0]), .level(level[0]), .drop_pulse(drop_pulse[0]));

    data_unpack_stream #(.IN_W(32), .OUT_W(7), .MSB_FIRST(1'b0), .PAD_PARTIAL(1'b0)) dut_drop (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
        .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
        .out_last(out_last[1]), .out_ready(out_ready[1]), .level(level[1]), .drop_pulse(drop_pulse[1]));

    data_unpack_stream #(.IN_W(32), .OUT_W(7), .MSB_FIRST(1'b1), .PAD_PARTIAL(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_last(in_last[2]),
        .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
        .out_last(out_last[2]), .out_ready(out_ready[2]), .level(level[2]), .drop_pulse(drop_pulse[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data[k]   = 32'h0;
            in_valid[k]  = 1'b0;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Push one word into instance k, then drain with out_ready high for a fixed window.
    task automatic run_word(input int k, input logic [31:0] word, input bit last,
                            output int n, output logic [6:0] first, output logic [6:0] fin,
                            output bit fin_last, output int nlast, output int drops);
        n = 0; first = 7'h0; fin = 7'h0; fin_last = 1'b0; nlast = 0; drops = 0;
        check($sformatf("in_ready_before_push[%0d]", k), 32'(in_ready[k]), 32'd1);
        in_data[k]   = word;
        in_valid[k]  = 1'b1;
        in_last[k]   = last;
        out_ready[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        if (last) begin
            check($sformatf("in_blocked_after_last[%0d]", k), 32'(in_ready[k]), 32'd0);
        end
        for (int c = 0; c < 12; c++) begin
            if (out_valid[k]) begin
                n++;
                if (n == 1) first = out_data[k];
                fin      = out_data[k];
                fin_last = out_last[k];
                if (out_last[k]) nlast++;
            end
            if (drop_pulse[k]) drops++;
            @(negedge clk);
        end
        out_ready[k] = 1'b0;
    endtask

    // Seven words through instance 0 against a flat bit-vector reference.
    task automatic run_stream(input int pct, input bit use_last);
        logic [31:0]  w [7];
        logic [223:0] bits;
        logic [6:0]   prev_data;
        logic         prev_last;
        bit           prev_stall;
        int           pushed;
        int           popped;
        int           cyc;
        for (int j = 0; j < 7; j++) begin
            w[j] = 32'h9E3779B9 * 32'(j + 1);
            bits[32*j +: 32] = w[j];
        end
        pushed = 0; popped = 0; cyc = 0; prev_stall = 1'b0; prev_data = 7'h0; prev_last = 1'b0;
        while (popped < 32 && cyc < 3000) begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid[0]), 32'd1);
                check("stall_data", 32'(out_data[0]), 32'(prev_data));
                check("stall_last", 32'(out_last[0]), 32'(prev_last));
            end
            in_valid[0]  = (pushed < 7);
            in_data[0]   = (pushed < 7) ? w[pushed] : 32'h0;
            in_last[0]   = use_last && (pushed == 6);
            out_ready[0] = ($urandom_range(0, 99) < pct);
            if (in_valid[0] && in_ready[0]) pushed++;
            if (out_valid[0] && out_ready[0]) begin
                check($sformatf("stream_pkt%0d", popped), 32'(out_data[0]), 32'(bits[7*popped +: 7]));
                check($sformatf("stream_last%0d", popped), 32'(out_last[0]),
                      32'(use_last && popped == 31));
                popped++;
            end
            prev_stall = out_valid[0] && !out_ready[0];
            prev_data  = out_data[0];
            prev_last  = out_last[0];
            @(negedge clk);
            cyc++;
        end
        in_valid[0]  = 1'b0;
        in_last[0]   = 1'b0;
        out_ready[0] = 1'b0;
        check("stream_count", 32'(popped), 32'd32);
        check("stream_level_end", 32'(level[0]), 32'd0);
        check("stream_valid_end", 32'(out_valid[0]), 32'd0);
        check("stream_ready_end", 32'(in_ready[0]), 32'd1);
    endtask

    initial begin
        vec_t        vecs [8];
        int          n, nlast, drops;
        logic [6:0]  first, fin;
        bit          fin_last;

        vecs[0] = '{0, 32'h76543210, 1'b0, 4, 7'h10, 7'h32, 1'b0, 0, 4};
        vecs[1] = '{0, 32'h76543210, 1'b1, 5, 7'h10, 7'h07, 1'b1, 0, 0};
        vecs[2] = '{1, 32'h76543210, 1'b1, 4, 7'h10, 7'h32, 1'b1, 1, 0};
        vecs[3] = '{2, 32'h80000000, 1'b0, 4, 7'h40, 7'h00, 1'b0, 0, 4};
        vecs[4] = '{0, 32'hFFFFFFFF, 1'b1, 5, 7'h7F, 7'h0F, 1'b1, 0, 0};
        vecs[5] = '{1, 32'hFFFFFFFF, 1'b0, 4, 7'h7F, 7'h7F, 1'b0, 0, 4};
        vecs[6] = '{2, 32'h7654321F, 1'b1, 5, 7'h3B, 7'h78, 1'b1, 0, 0};
        vecs[7] = '{1, 32'hFFFFFFFF, 1'b1, 4, 7'h7F, 7'h7F, 1'b1, 1, 0};

        rst = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_in_ready[%0d]", k), 32'(in_ready[k]), 32'd1);
            check($sformatf("reset_out_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
            check($sformatf("reset_level[%0d]", k), 32'(level[k]), 32'd0);
            check($sformatf("reset_drop[%0d]", k), 32'(drop_pulse[k]), 32'd0);
            check($sformatf("reset_out_last[%0d]", k), 32'(out_last[k]), 32'd0);
        end

        for (int v = 0; v < 8; v++) begin
            do_reset();
            run_word(vecs[v].k, vecs[v].word, vecs[v].last, n, first, fin, fin_last, nlast, drops);
            check($sformatf("v%0d_count", v), 32'(n), 32'(vecs[v].n));
            check($sformatf("v%0d_first", v), 32'(first), 32'(vecs[v].first));
            check($sformatf("v%0d_final", v), 32'(fin), 32'(vecs[v].fin));
            check($sformatf("v%0d_final_last", v), 32'(fin_last), 32'(vecs[v].fin_last));
            check($sformatf("v%0d_num_last", v), 32'(nlast), 32'(vecs[v].last));
            check($sformatf("v%0d_drops", v), 32'(drops), 32'(vecs[v].drops));
            check($sformatf("v%0d_level", v), 32'(level[vecs[v].k]), 32'(vecs[v].lvl));
            check($sformatf("v%0d_in_ready", v), 32'(in_ready[vecs[v].k]), 32'd1);
            check($sformatf("v%0d_out_valid", v), 32'(out_valid[vecs[v].k]), 32'd0);
        end

        do_reset();
        run_stream(100, 1'b0);

        do_reset();
        run_stream(30, 1'b1);

        // Reset in the middle of a word: level 32 -> two pops -> 18, then rst.
        do_reset();
        in_data[0]  = 32'hDEADBEEF;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        repeat (2) @(negedge clk);
        out_ready[0] = 1'b0;
        check("mid_level_before_rst", 32'(level[0]), 32'd18);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_level_after_rst", 32'(level[0]), 32'd0);
        check("mid_valid_after_rst", 32'(out_valid[0]), 32'd0);
        run_word(0, 32'h76543210, 1'b0, n, first, fin, fin_last, nlast, drops);
        check("mid_post_first", 32'(first), 32'h10);
        check("mid_post_count", 32'(n), 32'd4);
        check("mid_post_level", 32'(level[0]), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
